// File: rtl/go_pkg.sv
// Shared types and helpers for the Go game controller: cell encoding, FSM states,
// game-result codes and the special PASS/RESIGN move words.
package go_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] BLACK = 2'b01;
    localparam logic [1:0] WHITE = 2'b10;

    typedef enum logic [1:0] {
        RES_NONE        = 2'b00,
        RES_DOUBLE_PASS = 2'b01,
        RES_RESIGN      = 2'b10,
        RES_TIMEOUT     = 2'b11
    } result_e;

    typedef enum logic [2:0] {
        WAIT_MOVE,
        REQ,
        CHECK,
        COMMIT,
        PASS_ST,
        ANNOUNCE,
        END_ST,
        GAME_OVER
    } state_e;

    // Special move words live at the top of the code space, above any legal coordinate.
    function automatic logic [31:0] pass_code(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] resign_code(input int w);
        return pass_code(w) - 32'd1;
    endfunction

    function automatic int cell_idx(input int r, input int c, input int n);
        return 2 * (r * n + c);
    endfunction

endpackage

// File: rtl/go_move_timer.sv
// Per-move time limit: counts cycles while enabled and flags the cycle in which
// the limit is reached. A limit of zero never expires.
module go_move_timer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
    input  logic clk_in,
    input  logic reset,
    input  logic enable,
    output logic expired
);

    logic [31:0] count;

    always_ff @(posedge clk_in) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 32'd1;
        end
    end

    // The first enabled cycle sees count 0, so the limit is hit on count == limit-1.
    assign expired = enable && (TIMEOUT_CYCLES != 32'd0) &&
                     (count == TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/go_game_ctrl.sv
// Go game controller: owns board, ko snapshot, turn and game result, and drives an
// external rules engine. Define MOVE_TIMER_EN to enable the per-move time limit.
module go_game_ctrl
    import go_pkg::*;
#(
    parameter int          BOARD_N        = 9,
    parameter int          COORD_W        = $clog2(BOARD_N),
    parameter int          MOVE_W         = 2 * COORD_W,
    parameter int          CNT_W          = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
    input  logic                           clk_in,
    input  logic                           reset,
    input  logic                           move_avail,
    input  logic [MOVE_W-1:0]              move,
    input  logic                           my_color,
    output logic                           upd_start,
    output logic [MOVE_W-1:0]              upd_move,
    input  logic                           upd_valid,
    input  logic                           upd_invalid,
    input  logic [2*BOARD_N*BOARD_N-1:0]   next_board,
    output logic [2*BOARD_N*BOARD_N-1:0]   board_bus,
    output logic [2*BOARD_N*BOARD_N-1:0]   ko_board,
    output logic                           turn,
    output logic                           busy,
    output logic                           tx_ready,
    output logic [MOVE_W-1:0]              tx_move,
    output logic                           invalid_move,
    output logic [CNT_W-1:0]               move_count,
    output logic                           game_over,
    output logic [1:0]                     result,
    output logic                           winner
);

    localparam logic [MOVE_W-1:0] PASS_MV   = MOVE_W'(pass_code(MOVE_W));
    localparam logic [MOVE_W-1:0] RESIGN_MV = MOVE_W'(resign_code(MOVE_W));

    state_e             state;
    result_e            res_q;
    logic               pass_streak;
    logic               timeout_hit;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               off_board;

    assign row       = move[MOVE_W-1 -: COORD_W];
    assign col       = move[COORD_W-1:0];
    assign off_board = (int'(row) >= BOARD_N) || (int'(col) >= BOARD_N);
    assign busy      = (state != WAIT_MOVE);
    assign result    = res_q;

`ifdef MOVE_TIMER_EN
    go_move_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_in (clk_in),
        .reset  (reset),
        .enable (state == WAIT_MOVE),
        .expired(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;

    // The time limit only takes effect when the timer is built in.
    if (TIMEOUT_CYCLES != 32'd0) begin : g_timer_absent
    end
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state        <= WAIT_MOVE;
            board_bus    <= '0;
            ko_board     <= '0;
            turn         <= 1'b0;
            upd_start    <= 1'b0;
            upd_move     <= '0;
            tx_ready     <= 1'b0;
            tx_move      <= '0;
            invalid_move <= 1'b0;
            move_count   <= '0;
            game_over    <= 1'b0;
            res_q        <= RES_NONE;
            winner       <= 1'b0;
            pass_streak  <= 1'b0;
        end else begin
            upd_start    <= 1'b0;
            tx_ready     <= 1'b0;
            invalid_move <= 1'b0;
            case (state)
                WAIT_MOVE: begin
                    // An expiring clock beats a move arriving in the same cycle.
                    if (timeout_hit) begin
                        upd_move <= RESIGN_MV;
                        res_q    <= RES_TIMEOUT;
                        winner   <= ~turn;
                        state    <= END_ST;
                    end else if (move_avail) begin
                        upd_move <= move;
                        if (move == PASS_MV) begin
                            state <= PASS_ST;
                        end else if (move == RESIGN_MV) begin
                            res_q  <= RES_RESIGN;
                            winner <= ~turn;
                            state  <= END_ST;
                        end else if (off_board) begin
                            invalid_move <= 1'b1;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    upd_start <= 1'b1;
                    state     <= CHECK;
                end
                CHECK: begin
                    if (upd_invalid) begin
                        invalid_move <= 1'b1;
                        state        <= WAIT_MOVE;
                    end else if (upd_valid) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    ko_board    <= board_bus;
                    board_bus   <= next_board;
                    pass_streak <= 1'b0;
                    state       <= ANNOUNCE;
                end
                PASS_ST: begin
                    pass_streak <= 1'b1;
                    if (pass_streak) begin
                        res_q  <= RES_DOUBLE_PASS;
                        winner <= 1'b0;
                        state  <= END_ST;
                    end else begin
                        state <= ANNOUNCE;
                    end
                end
                ANNOUNCE: begin
                    tx_ready <= (turn == my_color);
                    tx_move  <= upd_move;
                    turn     <= ~turn;
                    if (move_count != '1) move_count <= move_count + 1'b1;
                    state    <= WAIT_MOVE;
                end
                END_ST: begin
                    tx_ready  <= (turn == my_color);
                    tx_move   <= upd_move;
                    if (move_count != '1) move_count <= move_count + 1'b1;
                    game_over <= 1'b1;
                    state     <= GAME_OVER;
                end
                GAME_OVER: begin
                    state <= GAME_OVER;
                end
                default: state <= WAIT_MOVE;
            endcase
        end
    end

endmodule

// File: tb/tb_go_game_ctrl.sv
// Table-driven bench for go_game_ctrl on a 9x9 board, plus hand-written sequences
// for game-over freezing, mid-operation reset and (with MOVE_TIMER_EN) timeout.
module tb_go_game_ctrl;
    import go_pkg::*;

    localparam int N  = 9;
    localparam int BW = 2 * N * N;
    localparam int MW = 8;

    typedef struct {
        bit          rst;
        logic [7:0]  mv;
        bit          color;
        int          resp;      // 0 none, 1 valid, 2 invalid, 3 both
        bit          poke;
        int          exp_start;
        int          exp_inv;
        int          exp_tx;
        logic [7:0]  exp_txmv;
        bit          exp_turn;
        int          exp_count;
        bit          exp_go;
        logic [1:0]  exp_res;
        bit          exp_win;
    } vec_t;

    logic            clk_in = 1'b0;
    logic            reset = 1'b1;
    logic            move_avail = 1'b0;
    logic [MW-1:0]   move = '0;
    logic            my_color = 1'b0;
    logic            upd_valid = 1'b0;
    logic            upd_invalid = 1'b0;
    logic [BW-1:0]   next_board = '0;
    logic            upd_start;
    logic [MW-1:0]   upd_move;
    logic [BW-1:0]   board_bus;
    logic [BW-1:0]   ko_board;
    logic            turn;
    logic            busy;
    logic            tx_ready;
    logic [MW-1:0]   tx_move;
    logic            invalid_move;
    logic [15:0]     move_count;
    logic            game_over;
    logic [1:0]      result;
    logic            winner;

    int              errors = 0;
    int              checks = 0;
    logic [BW-1:0]   board_m = '0;
    logic [BW-1:0]   ko_m = '0;
    bit              m_turn = 1'b0;
    vec_t            vecs[12];

    go_game_ctrl #(
        .BOARD_N(N),
        .CNT_W(16),
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clk_in(clk_in), .reset(reset), .move_avail(move_avail), .move(move),
        .my_color(my_color), .upd_start(upd_start), .upd_move(upd_move),
        .upd_valid(upd_valid), .upd_invalid(upd_invalid), .next_board(next_board),
        .board_bus(board_bus), .ko_board(ko_board), .turn(turn), .busy(busy),
        .tx_ready(tx_ready), .tx_move(tx_move), .invalid_move(invalid_move),
        .move_count(move_count), .game_over(game_over), .result(result), .winner(winner)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_output(input string name, input logic [255:0] actual,
                                input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset = 1'b1; move_avail = 1'b0; upd_valid = 1'b0; upd_invalid = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        board_m = '0; ko_m = '0; m_turn = 1'b0;
    endtask

    task automatic apply_stimulus(input int r, input vec_t v);
        logic [BW-1:0] nb;
        logic [7:0]    txmv;
        int            idx, starts, invs, txs, start_cyc;
        bit            done;
        if (v.rst) do_reset();
        my_color = v.color;
        nb = board_m;
        if (v.resp == 1) begin
            idx = cell_idx(int'(v.mv[7:4]), int'(v.mv[3:0]), N);
            nb[idx +: 2] = m_turn ? WHITE : BLACK;
            next_board = nb;
        end else begin
            next_board = '1;
        end
        @(negedge clk_in);
        move = v.mv; move_avail = 1'b1;
        starts = 0; invs = 0; txs = 0; start_cyc = -1; txmv = '0; done = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(negedge clk_in);
            move_avail = 1'b0; upd_valid = 1'b0; upd_invalid = 1'b0;
            if (v.poke && cyc == 0) begin
                move_avail = 1'b1; move = 8'h55;
            end
            if (upd_start) begin
                starts++; start_cyc = cyc;
                check_output($sformatf("r%0d_upd_move", r), upd_move, v.mv);
                upd_valid   = (v.resp == 1 || v.resp == 3);
                upd_invalid = (v.resp == 2 || v.resp == 3);
            end
            if (tx_ready) begin txs++; txmv = tx_move; end
            if (invalid_move) invs++;
            if (v.exp_go ? game_over : !busy) done = 1'b1;
        end
        check_output($sformatf("r%0d_done", r), done, 1);
        check_output($sformatf("r%0d_starts", r), starts, v.exp_start);
        if (v.exp_start != 0) check_output($sformatf("r%0d_start_lat", r), start_cyc, 1);
        check_output($sformatf("r%0d_invalid", r), invs, v.exp_inv);
        check_output($sformatf("r%0d_tx", r), txs, v.exp_tx);
        if (v.exp_tx != 0) check_output($sformatf("r%0d_tx_move", r), txmv, v.exp_txmv);
        check_output($sformatf("r%0d_turn", r), turn, v.exp_turn);
        check_output($sformatf("r%0d_count", r), move_count, v.exp_count);
        check_output($sformatf("r%0d_game_over", r), game_over, v.exp_go);
        check_output($sformatf("r%0d_result", r), result, v.exp_res);
        check_output($sformatf("r%0d_winner", r), winner, v.exp_win);
        if (v.resp == 1) begin ko_m = board_m; board_m = nb; end
        check_output($sformatf("r%0d_board", r), board_bus, board_m);
        check_output($sformatf("r%0d_ko", r), ko_board, ko_m);
        m_turn = v.exp_turn;
    endtask

    initial begin
        int starts, cnt, txs;
        logic [7:0] txmv;

        //          rst   mv     col   rsp poke  st inv tx txmv   turn cnt go    res    win
        vecs[0]  = '{1'b0, 8'h33, 1'b0, 1, 1'b0, 1, 0, 1, 8'h33, 1'b1, 1, 1'b0, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 8'h9A, 1'b0, 0, 1'b0, 0, 1, 0, 8'h00, 1'b1, 1, 1'b0, 2'b00, 1'b0};
        vecs[2]  = '{1'b0, 8'h44, 1'b0, 2, 1'b0, 1, 1, 0, 8'h00, 1'b1, 1, 1'b0, 2'b00, 1'b0};
        vecs[3]  = '{1'b0, 8'h44, 1'b0, 1, 1'b0, 1, 0, 0, 8'h00, 1'b0, 2, 1'b0, 2'b00, 1'b0};
        vecs[4]  = '{1'b0, 8'hFF, 1'b0, 0, 1'b0, 0, 0, 1, 8'hFF, 1'b1, 3, 1'b0, 2'b00, 1'b0};
        vecs[5]  = '{1'b0, 8'h08, 1'b0, 1, 1'b0, 1, 0, 0, 8'h00, 1'b0, 4, 1'b0, 2'b00, 1'b0};
        vecs[6]  = '{1'b0, 8'hFF, 1'b0, 0, 1'b0, 0, 0, 1, 8'hFF, 1'b1, 5, 1'b0, 2'b00, 1'b0};
        vecs[7]  = '{1'b0, 8'h49, 1'b0, 0, 1'b0, 0, 1, 0, 8'h00, 1'b1, 5, 1'b0, 2'b00, 1'b0};
        vecs[8]  = '{1'b0, 8'h11, 1'b0, 3, 1'b0, 1, 1, 0, 8'h00, 1'b1, 5, 1'b0, 2'b00, 1'b0};
        vecs[9]  = '{1'b0, 8'hFF, 1'b1, 0, 1'b0, 0, 0, 1, 8'hFF, 1'b1, 6, 1'b1, 2'b01, 1'b0};
        vecs[10] = '{1'b1, 8'h00, 1'b1, 1, 1'b1, 1, 0, 0, 8'h00, 1'b1, 1, 1'b0, 2'b00, 1'b0};
        vecs[11] = '{1'b0, 8'hFE, 1'b1, 0, 1'b0, 0, 0, 1, 8'hFE, 1'b1, 2, 1'b1, 2'b10, 1'b0};

        do_reset();
        check_output("rst_board", board_bus, 0);
        check_output("rst_ko", ko_board, 0);
        check_output("rst_turn", turn, 0);
        check_output("rst_count", move_count, 0);
        check_output("rst_result", result, 0);
        check_output("rst_game_over", game_over, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_pulses", {upd_start, tx_ready, invalid_move}, 0);

        for (int r = 0; r < 10; r++) apply_stimulus(r, vecs[r]);

        // Game over is absorbing: a further move must be ignored.
        @(negedge clk_in);
        move = 8'h22; move_avail = 1'b1; next_board = '1;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            move_avail = 1'b0;
            if (upd_start) starts++;
        end
        check_output("go_no_start", starts, 0);
        check_output("go_count", move_count, 6);
        check_output("go_level", game_over, 1);
        check_output("go_board", board_bus, board_m);
        check_output("go_result", result, 2'b01);

        for (int r = 10; r < 12; r++) apply_stimulus(r, vecs[r]);

        // Reset while waiting on the updater; a late upd_valid must be ignored.
        do_reset();
        my_color = 1'b0;
        next_board = '1;
        @(negedge clk_in);
        move = 8'h22; move_avail = 1'b1;
        @(negedge clk_in);
        move_avail = 1'b0;
        @(negedge clk_in);
        check_output("mid_start", upd_start, 1);
        reset = 1'b1;
        @(negedge clk_in);
        check_output("mid_busy", busy, 0);
        reset = 1'b0; upd_valid = 1'b1;
        @(negedge clk_in);
        upd_valid = 1'b0;
        repeat (4) @(negedge clk_in);
        check_output("mid_board", board_bus, 0);
        check_output("mid_ko", ko_board, 0);
        check_output("mid_turn", turn, 0);
        check_output("mid_count", move_count, 0);
        check_output("mid_idle", busy, 0);

`ifdef MOVE_TIMER_EN
        do_reset();
        my_color = 1'b0;
        cnt = 0; txs = 0; txmv = '0;
        while (!game_over && cnt < 300) begin
            @(negedge clk_in);
            cnt++;
            if (tx_ready) begin txs++; txmv = tx_move; end
        end
        check_output("to_game_over", game_over, 1);
        check_output("to_cycles", (cnt >= 95 && cnt <= 110), 1);
        check_output("to_result", result, 2'b11);
        check_output("to_winner", winner, 1);
        check_output("to_count", move_count, 1);
        check_output("to_tx", txs, 1);
        check_output("to_tx_move", txmv, 8'hFE);
`else
        cnt = 0; txs = 0; txmv = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
